// File: rtl/io_mmtx_mc.sv
// io_mmtx_mc: multi-channel store-and-forward transmit buffer.
// Patches each packet header with its destination port and slot number.
// Bad packets are rewound out of the buffer, so they are never emitted.
module io_mmtx_mc #(
    parameter int CH_NUM  = 4,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 2048,
    parameter int MAX_LEN = 512
) (
    input  logic                    clk_12_5m,
    input  logic                    rst_12_5m,
    input  logic [2*CH_NUM-1:0]     destin_port,
    input  logic [4:0]              self_slot_num,
    input  logic [CH_NUM-1:0]       wr_sel,
    input  logic                    wr_dval,
    input  logic                    wr_sop,
    input  logic                    wr_eop,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_req,
    output logic                    rd_dval,
    output logic [DATA_W+1:0]       rd_data,
    output logic [$clog2(DEPTH):0]  pkt_cnt,
    output logic [15:0]             drop_cnt,
    output logic                    drop_pulse
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int IDX_W  = $clog2(MAX_LEN + 1);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    logic [CH_NUM-1:0]  r_sel;
    logic               r_dval;
    logic               r_sop;
    logic               r_eop;
    logic [DATA_W-1:0]  r_data;

    state_t             r_state;
    logic [CH_NUM-1:0]  r_chan;
    logic [IDX_W-1:0]   r_idx;
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_startPtr;
    logic [PTR_W-1:0]   r_commitPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [DATA_W+1:0]  r_mem [DEPTH];
    logic               r_rdDval;
    logic [DATA_W+1:0]  r_rdData;
    logic [PTR_W-1:0]   r_pktCnt;
    logic [15:0]        r_dropCnt;
    logic               r_dropPulse;

    logic               w_full;
    logic               w_sopGo;
    logic               w_selBad;
    logic [IDX_W-1:0]   w_idxNext;
    logic [1:0]         w_dest;
    logic [DATA_W-1:0]  w_patched;
    logic               w_we;
    logic [PTR_W-1:0]   w_wptr;
    logic [DATA_W-1:0]  w_wword;
    logic               w_start;
    logic               w_commit;
    logic               w_drop;
    logic               w_rewind;
    logic               w_rdEn;
    logic               w_rdEop;

    assign w_full    = (r_wrPtr - r_rdPtr) == DEPTH_P;
    assign w_sopGo   = r_dval && r_sop && (r_sel != '0);
    assign w_selBad  = r_sel != r_chan;
    assign w_idxNext = r_idx + IDX_W'(1);
    assign w_rdEn    = rd_req && (r_rdPtr != r_commitPtr);
    assign w_rdEop   = w_rdEn && r_mem[r_rdPtr[ADDR_W-1:0]][DATA_W];

    // Input stage: register the write port for one cycle
    always_ff @(posedge clk_12_5m) begin
        if (!rst_12_5m) begin
            r_sel  <= '0;
            r_dval <= 1'b0;
            r_sop  <= 1'b0;
            r_eop  <= 1'b0;
            r_data <= '0;
        end else begin
            r_sel  <= wr_sel;
            r_dval <= wr_dval;
            r_sop  <= wr_sop;
            r_eop  <= wr_eop;
            r_data <= wr_data;
        end
    end

    // Header patch: pick the latched channel's port field, insert port/slot by word index
    always_comb begin
        w_dest = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (r_chan[c]) w_dest = w_dest | destin_port[2*c +: 2];
        end
        w_patched = r_data;
        if (w_idxNext == IDX_W'(1)) w_patched[9:8] = w_dest;
        if (w_idxNext == IDX_W'(2)) w_patched[6:2] = self_slot_num;
    end

    // Action decode: which word gets written where, and whether it commits or aborts
    always_comb begin
        w_we     = 1'b0;
        w_wptr   = r_wrPtr;
        w_wword  = w_patched;
        w_start  = 1'b0;
        w_commit = 1'b0;
        w_drop   = 1'b0;
        w_rewind = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sopGo) begin
                    if (w_full) begin
                        w_drop = 1'b1;
                    end else begin
                        w_we     = 1'b1;
                        w_wword  = r_data;
                        w_start  = 1'b1;
                        w_commit = r_eop;
                    end
                end
            end
            RECV: begin
                if (w_sopGo) begin
                    w_drop   = 1'b1;
                    w_we     = 1'b1;
                    w_wptr   = r_startPtr;
                    w_wword  = r_data;
                    w_start  = 1'b1;
                    w_commit = r_eop;
                end else if (w_selBad) begin
                    w_drop   = 1'b1;
                    w_rewind = 1'b1;
                end else if (r_dval) begin
                    if (w_full || (w_idxNext == MAX_IDX)) begin
                        w_drop   = 1'b1;
                        w_rewind = 1'b1;
                    end else begin
                        w_we     = 1'b1;
                        w_commit = r_eop;
                    end
                end
            end
            default: ;
        endcase
    end

    // Packet buffer write port; nothing is written while reset is held
    always_ff @(posedge clk_12_5m) begin
        if (rst_12_5m && w_we) r_mem[w_wptr[ADDR_W-1:0]] <= {r_sop, r_eop, w_wword};
    end

    // Receive FSM: write pointer, commit/rewind, channel latch and drop accounting
    always_ff @(posedge clk_12_5m) begin
        if (!rst_12_5m) begin
            r_state     <= IDLE;
            r_chan      <= '0;
            r_idx       <= '0;
            r_wrPtr     <= '0;
            r_startPtr  <= '0;
            r_commitPtr <= '0;
            r_dropCnt   <= '0;
            r_dropPulse <= 1'b0;
        end else begin
            if (w_we)          r_wrPtr <= w_wptr + PTR_W'(1);
            else if (w_rewind) r_wrPtr <= r_startPtr;
            if (w_commit) r_commitPtr <= w_wptr + PTR_W'(1);
            if (w_start) begin
                r_startPtr <= w_wptr;
                r_chan     <= r_sel;
                r_idx      <= '0;
            end else if (w_we) begin
                r_idx <= w_idxNext;
            end
            r_dropPulse <= w_drop;
            if (w_drop && (r_dropCnt != 16'hFFFF)) r_dropCnt <= r_dropCnt + 16'd1;
            case (r_state)
                IDLE: begin
                    if (w_sopGo) begin
                        if (w_full)      r_state <= r_eop ? IDLE : DISCARD;
                        else if (!r_eop) r_state <= RECV;
                    end
                end
                RECV: begin
                    if (w_sopGo)       r_state <= r_eop ? IDLE : RECV;
                    else if (w_selBad) r_state <= IDLE;
                    else if (r_dval) begin
                        if (w_drop)     r_state <= r_eop ? IDLE : DISCARD;
                        else if (r_eop) r_state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (r_dval && r_eop) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read side: registered RAM output and complete-packet count
    always_ff @(posedge clk_12_5m) begin
        if (!rst_12_5m) begin
            r_rdPtr  <= '0;
            r_rdDval <= 1'b0;
            r_rdData <= '0;
            r_pktCnt <= '0;
        end else begin
            r_rdDval <= w_rdEn;
            if (w_rdEn) begin
                r_rdData <= r_mem[r_rdPtr[ADDR_W-1:0]];
                r_rdPtr  <= r_rdPtr + PTR_W'(1);
            end
            case ({w_commit, w_rdEop})
                2'b10:   r_pktCnt <= r_pktCnt + PTR_W'(1);
                2'b01:   r_pktCnt <= r_pktCnt - PTR_W'(1);
                default: ;
            endcase
        end
    end

    assign rd_dval    = r_rdDval;
    assign rd_data    = r_rdData;
    assign pkt_cnt    = r_pktCnt;
    assign drop_cnt   = r_dropCnt;
    assign drop_pulse = r_dropPulse;

endmodule

// File: tb/tb_io_mmtx_mc.sv
// tb_io_mmtx_mc: directed packets into io_mmtx_mc with a read-side scoreboard.
// Small buffer (16 words) and short packet limit (8 words) reach the overflow cases quickly.
module tb_io_mmtx_mc;
    localparam int CH_NUM  = 4;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 16;
    localparam int MAX_LEN = 8;

    logic        clk_12_5m = 1'b0;
    logic        rst_12_5m = 1'b0;
    logic [7:0]  destin_port;
    logic [4:0]  self_slot_num;
    logic [3:0]  wr_sel;
    logic        wr_dval;
    logic        wr_sop;
    logic        wr_eop;
    logic [15:0] wr_data;
    logic        rd_req;
    logic        rd_dval;
    logic [17:0] rd_data;
    logic [4:0]  pkt_cnt;
    logic [15:0] drop_cnt;
    logic        drop_pulse;

    int          nVec = 0;
    int          nErr = 0;
    int          cyc = 0;
    int          pulseCnt = 0;
    int          firstDval = -1;
    int          lastEopEdge = 0;
    bit          armFirst = 1'b0;
    logic [17:0] expQ [$];
    logic [15:0] pkt [16];

    io_mmtx_mc #(
        .CH_NUM(CH_NUM),
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk_12_5m(clk_12_5m),
        .rst_12_5m(rst_12_5m),
        .destin_port(destin_port),
        .self_slot_num(self_slot_num),
        .wr_sel(wr_sel),
        .wr_dval(wr_dval),
        .wr_sop(wr_sop),
        .wr_eop(wr_eop),
        .wr_data(wr_data),
        .rd_req(rd_req),
        .rd_dval(rd_dval),
        .rd_data(rd_data),
        .pkt_cnt(pkt_cnt),
        .drop_cnt(drop_cnt),
        .drop_pulse(drop_pulse)
    );

    // Free-running clock
    always #5 clk_12_5m = ~clk_12_5m;

    // Count rising edges so read latency can be measured against the eop edge
    always @(posedge clk_12_5m) cyc <= cyc + 1;

    // Monitor: count drop pulses and compare every valid read word with the scoreboard
    always @(negedge clk_12_5m) begin
        logic [17:0] expWord;
        if (drop_pulse === 1'b1) pulseCnt++;
        if (rd_dval === 1'b1) begin
            if (armFirst && firstDval < 0) firstDval = cyc;
            nVec++;
            if (expQ.size() == 0) begin
                nErr++;
                $display("[TB] FAIL readUnexpected: got %h, required no read word", rd_data);
            end else begin
                expWord = expQ.pop_front();
                if (rd_data !== expWord) begin
                    nErr++;
                    $display("[TB] FAIL readData: got %h, required %h", rd_data, expWord);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nVec++;
        if (act !== req) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic pushExp(input logic sop, input logic eop, input logic [15:0] w);
        expQ.push_back({sop, eop, w});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            wr_dval = 1'b0;
            wr_sop  = 1'b0;
            wr_eop  = 1'b0;
            @(negedge clk_12_5m);
        end
    endtask

    task automatic sendWord(input logic [3:0] sel, input logic sop, input logic eop, input logic [15:0] d);
        wr_sel  = sel;
        wr_dval = 1'b1;
        wr_sop  = sop;
        wr_eop  = eop;
        wr_data = d;
        @(negedge clk_12_5m);
        wr_dval = 1'b0;
        wr_sop  = 1'b0;
        wr_eop  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] sel, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) lastEopEdge = cyc + 1;
            sendWord(sel, i == 0, i == n - 1, pkt[i]);
            if (gap > 0 && i < n - 1) idle(gap);
        end
        wr_sel = '0;
    endtask

    task automatic readWords(input int n);
        rd_req = 1'b1;
        repeat (n) @(negedge clk_12_5m);
        rd_req = 1'b0;
    endtask

    task automatic waitDrain();
        int t = 0;
        while (expQ.size() != 0 && t < 200) begin
            @(negedge clk_12_5m);
            t++;
        end
        nVec++;
        if (expQ.size() != 0) begin
            nErr++;
            $display("[TB] FAIL drain: got %0d words still expected, required 0", expQ.size());
            expQ.delete();
        end
        idle(2);
    endtask

    initial begin
        destin_port   = 8'b10_11_01_00;
        self_slot_num = 5'd9;
        wr_sel  = '0;
        wr_dval = 1'b0;
        wr_sop  = 1'b0;
        wr_eop  = 1'b0;
        wr_data = '0;
        rd_req  = 1'b0;
        repeat (3) @(negedge clk_12_5m);

        checkOutput("resetRdDval", 32'(rd_dval), 0);
        checkOutput("resetRdData", 32'(rd_data), 0);
        checkOutput("resetPktCnt", 32'(pkt_cnt), 0);
        checkOutput("resetDropCnt", 32'(drop_cnt), 0);
        checkOutput("resetDropPulse", 32'(drop_pulse), 0);
        rst_12_5m = 1'b1;
        idle(1);

        $display("[TB] basic 4-word packet on channel 2");
        pkt[0] = 16'h1234; pkt[1] = 16'h0000; pkt[2] = 16'hFFFF; pkt[3] = 16'hABCD;
        pushExp(1'b1, 1'b0, 16'h1234);
        pushExp(1'b0, 1'b0, 16'h0300);
        pushExp(1'b0, 1'b0, 16'hFFA7);
        pushExp(1'b0, 1'b1, 16'hABCD);
        applyStimulus(4'b0100, 4, 0);
        idle(3);
        checkOutput("basicPktCnt", 32'(pkt_cnt), 1);
        readWords(4);
        waitDrain();
        checkOutput("basicPktCntAfterRead", 32'(pkt_cnt), 0);

        $display("[TB] same packet with 3-cycle gaps, read requested throughout");
        pushExp(1'b1, 1'b0, 16'h1234);
        pushExp(1'b0, 1'b0, 16'h0300);
        pushExp(1'b0, 1'b0, 16'hFFA7);
        pushExp(1'b0, 1'b1, 16'hABCD);
        firstDval = -1;
        armFirst  = 1'b1;
        rd_req    = 1'b1;
        applyStimulus(4'b0100, 4, 3);
        waitDrain();
        rd_req   = 1'b0;
        armFirst = 1'b0;
        checkOutput("gapFirstReadCycle", 32'(firstDval), 32'(lastEopEdge + 2));
        checkOutput("gapPktCnt", 32'(pkt_cnt), 0);

        $display("[TB] new sop in the middle of a packet");
        pulseCnt = 0;
        sendWord(4'b0010, 1'b1, 1'b0, 16'h1111);
        sendWord(4'b0010, 1'b0, 1'b0, 16'h2222);
        pushExp(1'b1, 1'b0, 16'h5555);
        pushExp(1'b0, 1'b0, 16'h0100);
        pushExp(1'b0, 1'b1, 16'h0024);
        sendWord(4'b0010, 1'b1, 1'b0, 16'h5555);
        sendWord(4'b0010, 1'b0, 1'b0, 16'h0000);
        sendWord(4'b0010, 1'b0, 1'b1, 16'h0000);
        wr_sel = '0;
        idle(3);
        checkOutput("resopDropCnt", 32'(drop_cnt), 1);
        checkOutput("resopPulses", 32'(pulseCnt), 1);
        checkOutput("resopPktCnt", 32'(pkt_cnt), 1);
        readWords(3);
        waitDrain();

        $display("[TB] 10-word packet exceeds length limit of 8");
        pulseCnt = 0;
        for (int i = 0; i < 10; i++) pkt[i] = 16'h3000 + 16'(i);
        applyStimulus(4'b1000, 10, 0);
        idle(3);
        checkOutput("longDropCnt", 32'(drop_cnt), 2);
        checkOutput("longPulses", 32'(pulseCnt), 1);
        checkOutput("longPktCnt", 32'(pkt_cnt), 0);
        pkt[0] = 16'h0F0F; pkt[1] = 16'h0000;
        pushExp(1'b1, 1'b0, 16'h0F0F);
        pushExp(1'b0, 1'b1, 16'h0200);
        applyStimulus(4'b1000, 2, 0);
        idle(3);
        checkOutput("afterLongPktCnt", 32'(pkt_cnt), 1);
        readWords(2);
        waitDrain();

        $display("[TB] buffer overflow: 12 committed words then an 8-word packet");
        pulseCnt = 0;
        pkt[0] = 16'hC001; pkt[1] = 16'h0301; pkt[2] = 16'h0000; pkt[3] = 16'hE001;
        pushExp(1'b1, 1'b0, 16'hC001);
        pushExp(1'b0, 1'b0, 16'h0001);
        pushExp(1'b0, 1'b0, 16'h0024);
        pushExp(1'b0, 1'b1, 16'hE001);
        applyStimulus(4'b0001, 4, 0);
        pkt[0] = 16'hC002; pkt[1] = 16'h0302; pkt[2] = 16'h0000; pkt[3] = 16'hE002;
        pushExp(1'b1, 1'b0, 16'hC002);
        pushExp(1'b0, 1'b0, 16'h0002);
        pushExp(1'b0, 1'b0, 16'h0024);
        pushExp(1'b0, 1'b1, 16'hE002);
        applyStimulus(4'b0001, 4, 0);
        pkt[0] = 16'hC003; pkt[1] = 16'h0303; pkt[2] = 16'h0000; pkt[3] = 16'hE003;
        pushExp(1'b1, 1'b0, 16'hC003);
        pushExp(1'b0, 1'b0, 16'h0003);
        pushExp(1'b0, 1'b0, 16'h0024);
        pushExp(1'b0, 1'b1, 16'hE003);
        applyStimulus(4'b0001, 4, 0);
        idle(3);
        checkOutput("fillPktCnt", 32'(pkt_cnt), 3);
        for (int i = 0; i < 8; i++) pkt[i] = 16'h7000 + 16'(i);
        applyStimulus(4'b0010, 8, 0);
        idle(3);
        checkOutput("fullDropCnt", 32'(drop_cnt), 3);
        checkOutput("fullPulses", 32'(pulseCnt), 1);
        checkOutput("fullPktCnt", 32'(pkt_cnt), 3);
        readWords(12);
        waitDrain();
        checkOutput("fullPktCntAfterRead", 32'(pkt_cnt), 0);

        $display("[TB] reset during receive and during read");
        pkt[0] = 16'hC004; pkt[1] = 16'h0304; pkt[2] = 16'h0000; pkt[3] = 16'hE004;
        pushExp(1'b1, 1'b0, 16'hC004);
        pushExp(1'b0, 1'b0, 16'h0004);
        applyStimulus(4'b0001, 4, 0);
        sendWord(4'b0100, 1'b1, 1'b0, 16'h9999);
        sendWord(4'b0100, 1'b0, 1'b0, 16'h0000);
        idle(2);
        rd_req = 1'b1;
        @(negedge clk_12_5m);
        @(negedge clk_12_5m);
        rst_12_5m = 1'b0;
        rd_req    = 1'b0;
        wr_sel    = '0;
        @(negedge clk_12_5m);
        checkOutput("midResetRdDval", 32'(rd_dval), 0);
        checkOutput("midResetRdData", 32'(rd_data), 0);
        checkOutput("midResetPktCnt", 32'(pkt_cnt), 0);
        checkOutput("midResetDropCnt", 32'(drop_cnt), 0);
        checkOutput("midResetDropPulse", 32'(drop_pulse), 0);
        rst_12_5m = 1'b1;
        idle(1);
        pkt[0] = 16'h8888; pkt[1] = 16'h0000;
        pushExp(1'b1, 1'b0, 16'h8888);
        pushExp(1'b0, 1'b1, 16'h0300);
        applyStimulus(4'b0100, 2, 0);
        idle(3);
        checkOutput("postResetPktCnt", 32'(pkt_cnt), 1);
        readWords(2);
        waitDrain();
        checkOutput("postResetPktCntAfterRead", 32'(pkt_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
